// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared constants and elaboration-time helpers for the LED blinker and the
// button reader. Nothing here produces hardware on its own; the functions are
// evaluated at elaboration to size dividers and counters.
//
// Contents:
//   MS_PER_S        milliseconds per second, used to derive the ms tick
//   tick_div()      clock cycles per millisecond for a given clock frequency
//   clog2w()        bit width needed to hold values 0..value-1 (at least 1)
//   edge_kind_e     classification of a debounced transition
// -----------------------------------------------------------------------------
package blink_pkg;

    localparam int MS_PER_S = 1000;

    // Cycles per millisecond tick. Clamped to 1 so that a degenerate clock
    // setting still yields a legal divider (tick every cycle).
    function automatic int tick_div(input int clk_freq);
        int div;
        div = clk_freq / MS_PER_S;
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

    // Width of a counter that must represent 0..value-1. Never returns 0 so
    // the result can always be used directly as a vector width.
    function automatic int clog2w(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_e;

endpackage

// File: rtl/button_reader_if.sv
// -----------------------------------------------------------------------------
// button_reader_if
// Bundles the board-side pins and the debounced outputs of button_reader.
//
// Signals:
//   btn_raw       raw asynchronous button pins (driven by the board side)
//   btn_state     debounced level per button, 1 = pressed
//   btn_pressed   one-cycle pulse on an accepted press
//   btn_released  one-cycle pulse on an accepted release
//   tick_ms       one-cycle pulse per millisecond
//
// Modports:
//   master  board / consumer view: drives btn_raw, observes the results
//   slave   button_reader view: samples btn_raw, drives the results
// -----------------------------------------------------------------------------
interface button_reader_if #(
    parameter int N = 8
);

    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_state;
    logic [N-1:0] btn_pressed;
    logic [N-1:0] btn_released;
    logic         tick_ms;

    modport master (
        output btn_raw,
        input  btn_state,
        input  btn_pressed,
        input  btn_released,
        input  tick_ms
    );

    modport slave (
        input  btn_raw,
        output btn_state,
        output btn_pressed,
        output btn_released,
        output tick_ms
    );

endinterface

// File: rtl/button_reader_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// Single-bit debouncer driven by a shared millisecond tick. A change of the
// synchronized input is accepted only after it has persisted, without
// interruption, across DEBOUNCE_MS ticks. Any return to the current state
// restarts the qualification.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   s      synchronized input, 1 = pressed
//   tick   one-cycle millisecond pulse
//   state  debounced level
//   rise   one-cycle pulse in the first cycle of state = 1
//   fall   one-cycle pulse in the first cycle of state = 0
// -----------------------------------------------------------------------------
module debounce_cell
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic tick,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = clog2w(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             state_q;
    logic             state_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    edge_kind_e       edge_kind;

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        edge_kind = EDGE_NONE;

        if (s == state_q) begin
            // Input agrees with the published level: any partial count is
            // discarded so a bounce restarts qualification from scratch.
            cnt_d = '0;
        end else if (tick) begin
            // ">=" keeps the counter saturating even if it were ever to hold
            // an out-of-range value; it can never wrap past CNT_LAST.
            if (cnt_q >= CNT_LAST) begin
                state_d   = s;
                cnt_d     = '0;
                edge_kind = s ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        rise_d = (edge_kind == EDGE_RISE);
        fall_d = (edge_kind == EDGE_FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state = state_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
// Reads N raw board buttons: each pin is brought into the clock domain with a
// two-flop synchronizer, normalized so that 1 means pressed, and debounced
// against a shared millisecond tick. Publishes the stable level plus one-cycle
// press/release pulses, and exports the tick for other blocks.
//
// Ports:
//   clk    system clock (CLK_FREQ Hz)
//   rst_n  asynchronous active-low reset
//   bus    button_reader_if.slave
//            btn_raw      in   raw pins (INVERT=1: pressed reads 0)
//            btn_state    out  debounced level, 1 = pressed
//            btn_pressed  out  pulse on accepted 0->1 of btn_state
//            btn_released out  pulse on accepted 1->0 of btn_state
//            tick_ms      out  pulse once per millisecond
//
// Every output comes straight from a flop; there is no combinational path
// from btn_raw to any output.
// -----------------------------------------------------------------------------
module button_reader
    import blink_pkg::*;
#(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int N           = 8,
    parameter int DEBOUNCE_MS = 20,
    parameter bit INVERT      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    button_reader_if.slave  bus
);

    localparam int               TICK_DIV = tick_div(CLK_FREQ);
    localparam int               DIV_W    = clog2w(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    // Pin level of a released button; the synchronizer resets to it so that
    // leaving reset never looks like a press.
    localparam logic [N-1:0]     IDLE_PIN = {N{INVERT}};

    if (CLK_FREQ < MS_PER_S) begin : g_bad_clk_freq
        $error("button_reader: CLK_FREQ must be at least 1000");
    end
    if (DEBOUNCE_MS < 1) begin : g_bad_debounce
        $error("button_reader: DEBOUNCE_MS must be at least 1");
    end

    // ---------------------------------------------------------------------
    // Millisecond tick
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;

    // tick_q is registered but aligned with the divider: it is high in exactly
    // the cycle where div_q == TICK_DIV-1, so it is decoded from div_d.
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        tick_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // ---------------------------------------------------------------------
    // Two-flop synchronizer
    // ---------------------------------------------------------------------
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync1_d;
    logic [N-1:0] sync2_q;
    logic [N-1:0] sync2_d;
    logic [N-1:0] s_vec;

    always_comb begin
        sync1_d = bus.btn_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Normalize polarity: 1 = pressed regardless of board wiring.
    assign s_vec = sync2_q ^ IDLE_PIN;

    // ---------------------------------------------------------------------
    // Per-bit debounce
    // ---------------------------------------------------------------------
    logic [N-1:0] state_vec;
    logic [N-1:0] rise_vec;
    logic [N-1:0] fall_vec;

    for (genvar i = 0; i < N; i++) begin : g_bit
        debounce_cell #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .s     (s_vec[i]),
            .tick  (tick_q),
            .state (state_vec[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i])
        );
    end

    assign bus.btn_state    = state_vec;
    assign bus.btn_pressed  = rise_vec;
    assign bus.btn_released = fall_vec;
    assign bus.tick_ms      = tick_q;

endmodule

// File: tb/tb_button_reader.sv
`timescale 1ns/1ps
// Bench for button_reader: two instances (active-low and active-high pins)
// share clock and reset. A behavioural model tracks, per bit, how many
// millisecond ticks the normalized pin has disagreed with the published level;
// a compare process checks every output of both instances on every negedge.
// Directed scenarios add hand-computed literal expectations.
module tb_button_reader;

    localparam int N  = 8;
    localparam int CF = 10_000;
    localparam int DM = 4;
    localparam int TD = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_reader_if #(.N(N)) bus_a ();
    button_reader_if #(.N(N)) bus_b ();

    button_reader #(.CLK_FREQ(CF), .N(N), .DEBOUNCE_MS(DM), .INVERT(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    button_reader #(.CLK_FREQ(CF), .N(N), .DEBOUNCE_MS(DM), .INVERT(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [N-1:0] idle_pin(input int d);
        return (d == 0) ? {N{1'b1}} : {N{1'b0}};
    endfunction
    function automatic logic [N-1:0] raw_of(input int d);
        return (d == 0) ? bus_a.btn_raw : bus_b.btn_raw;
    endfunction
    function automatic logic [N-1:0] st_of(input int d);
        return (d == 0) ? bus_a.btn_state : bus_b.btn_state;
    endfunction
    function automatic logic [N-1:0] pr_of(input int d);
        return (d == 0) ? bus_a.btn_pressed : bus_b.btn_pressed;
    endfunction
    function automatic logic [N-1:0] rl_of(input int d);
        return (d == 0) ? bus_a.btn_released : bus_b.btn_released;
    endfunction
    function automatic logic tk_of(input int d);
        return (d == 0) ? bus_a.tick_ms : bus_b.tick_ms;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural model
    //   pin history: the pin value seen 2 clock edges ago is what counts
    //   ticks: the k-th clock period after reset release carries a tick
    //          whenever k is a multiple of TD
    //   debounce: a bit flips once its disagreement has spanned DM ticks
    // ------------------------------------------------------------------
    logic [N-1:0] m_hist1 [2];
    logic [N-1:0] m_hist2 [2];
    logic [N-1:0] m_state [2];
    logic [N-1:0] m_rise  [2];
    logic [N-1:0] m_fall  [2];
    int           m_ticks_seen [2][N];
    int           m_edges = 0;
    logic         m_tick  = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] s;
        logic         tick_before;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_hist1[d] = idle_pin(d);
                m_hist2[d] = idle_pin(d);
                m_state[d] = '0;
                m_rise[d]  = '0;
                m_fall[d]  = '0;
                for (int b = 0; b < N; b++) m_ticks_seen[d][b] = 0;
            end
            m_edges = 0;
            m_tick  = 1'b0;
        end else begin
            tick_before = m_tick;
            for (int d = 0; d < 2; d++) begin
                s = m_hist2[d] ^ idle_pin(d);
                m_rise[d] = '0;
                m_fall[d] = '0;
                for (int b = 0; b < N; b++) begin
                    if (s[b] == m_state[d][b]) begin
                        m_ticks_seen[d][b] = 0;
                    end else if (tick_before) begin
                        m_ticks_seen[d][b] = m_ticks_seen[d][b] + 1;
                        if (m_ticks_seen[d][b] == DM) begin
                            m_state[d][b]      = s[b];
                            m_ticks_seen[d][b] = 0;
                            if (s[b]) m_rise[d][b] = 1'b1;
                            else      m_fall[d][b] = 1'b1;
                        end
                    end
                end
                m_hist2[d] = m_hist1[d];
                m_hist1[d] = raw_of(d);
            end
            m_edges = m_edges + 1;
            m_tick  = ((m_edges % TD) == TD - 1);
        end
    end

    // Compare process: every negedge, both instances, all outputs.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk($sformatf("dut%0d_state_rst", d), 32'(st_of(d)), 32'd0);
                chk($sformatf("dut%0d_pressed_rst", d), 32'(pr_of(d)), 32'd0);
                chk($sformatf("dut%0d_released_rst", d), 32'(rl_of(d)), 32'd0);
                chk($sformatf("dut%0d_tick_rst", d), 32'(tk_of(d)), 32'd0);
            end else begin
                chk($sformatf("dut%0d_state", d), 32'(st_of(d)), 32'(m_state[d]));
                chk($sformatf("dut%0d_pressed", d), 32'(pr_of(d)), 32'(m_rise[d]));
                chk($sformatf("dut%0d_released", d), 32'(rl_of(d)), 32'(m_fall[d]));
                chk($sformatf("dut%0d_tick", d), 32'(tk_of(d)), 32'(m_tick));
            end
        end
    end

    // Pulse counters used by the directed literal checks.
    int cnt_p [2][N];
    int cnt_r [2][N];
    initial begin
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < N; b++) begin
                cnt_p[d][b] = 0;
                cnt_r[d][b] = 0;
            end
    end
    always @(negedge clk) begin
        for (int b = 0; b < N; b++) begin
            cnt_p[0][b] += int'(bus_a.btn_pressed[b]);
            cnt_r[0][b] += int'(bus_a.btn_released[b]);
            cnt_p[1][b] += int'(bus_b.btn_pressed[b]);
            cnt_r[1][b] += int'(bus_b.btn_released[b]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until dut d bit b shows btn_state == 1; reports the number
    // of clock edges since the caller's reference edge count.
    task automatic wait_state(input int d, input int b, input int ref_cyc,
                              input int max_cyc, output int edges, output bit ok);
        ok    = 1'b0;
        edges = -1;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (st_of(d)[b] === 1'b1) begin
                ok    = 1'b1;
                edges = cyc - ref_cyc;
                break;
            end
        end
    endtask

    initial begin
        int  edges;
        bit  ok;
        int  period;
        int  snap_p, snap_r, snap_p1, snap_p2;
        bus_a.btn_raw = 8'hFF;
        bus_b.btn_raw = 8'h00;
        rst_n = 1'b0;
        step(5);

        // ---- Reset release and tick phase ----
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", 32'(bus_a.btn_state), 32'd0);
        chk("reset_pressed", 32'(bus_a.btn_pressed), 32'd0);
        chk("reset_released", 32'(bus_a.btn_released), 32'd0);
        period = 1;
        while (bus_a.tick_ms !== 1'b1 && period < 30) begin
            @(negedge clk);
            period++;
        end
        chk("first_tick_period", 32'(period), 32'd10);
        period = 0;
        do begin
            @(negedge clk);
            period++;
        end while (bus_a.tick_ms !== 1'b1 && period < 30);
        chk("tick_spacing", 32'(period), 32'd10);

        // ---- Clean press of bit 0 ----
        step(3);
        bus_a.btn_raw[0] = 1'b0;
        wait_state(0, 0, cyc, 60, edges, ok);
        chk("press0_seen", 32'(ok), 32'd1);
        chk_range("press0_latency", edges, 33, 43);
        chk("press0_pulse", 32'(bus_a.btn_pressed), 32'h01);
        chk("press0_others", 32'(bus_a.btn_state), 32'h01);
        @(negedge clk);
        chk("press0_pulse_one_cycle", 32'(bus_a.btn_pressed[0]), 32'd0);

        // ---- Bounce on bit 3 ----
        step(1);
        snap_p = cnt_p[0][3];
        snap_r = cnt_r[0][3];
        bus_a.btn_raw[3] = 1'b0; step(25);
        bus_a.btn_raw[3] = 1'b1; step(5);
        bus_a.btn_raw[3] = 1'b0; step(25);
        bus_a.btn_raw[3] = 1'b1; step(50);
        chk("bounce3_state", 32'(bus_a.btn_state[3]), 32'd0);
        chk("bounce3_no_press", 32'(cnt_p[0][3] - snap_p), 32'd0);
        chk("bounce3_no_release", 32'(cnt_r[0][3] - snap_r), 32'd0);
        bus_a.btn_raw[3] = 1'b0; step(50);
        chk("hold3_state", 32'(bus_a.btn_state[3]), 32'd1);
        chk("hold3_one_press", 32'(cnt_p[0][3] - snap_p), 32'd1);

        // ---- Multi-bit release of bits 1 and 2 ----
        bus_a.btn_raw[2:1] = 2'b00; step(50);
        chk("multi_pressed_state", 32'(bus_a.btn_state[2:1]), 32'd3);
        snap_p1 = cnt_p[0][1];
        snap_p2 = cnt_p[0][2];
        snap_r  = cnt_r[0][1];
        snap_p  = cnt_r[0][2];
        bus_a.btn_raw[2:1] = 2'b11;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_a.btn_released[1] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("release1_seen", 32'(ok), 32'd1);
        chk("release12_same_cycle", 32'(bus_a.btn_released[2:1]), 32'd3);
        chk("release_no_press_pulse", 32'(bus_a.btn_pressed), 32'd0);
        step(10);
        chk("release1_count", 32'(cnt_r[0][1] - snap_r), 32'd1);
        chk("release2_count", 32'(cnt_r[0][2] - snap_p), 32'd1);
        chk("release_bits_no_press", 32'((cnt_p[0][1] - snap_p1) + (cnt_p[0][2] - snap_p2)), 32'd0);

        // ---- Reset in the middle of qualifying bit 5 ----
        snap_p = cnt_p[0][5];
        bus_a.btn_raw[5] = 1'b0;
        step(25);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_state", 32'(bus_a.btn_state), 32'd0);
            chk("midrst_pulse", 32'(bus_a.btn_pressed | bus_a.btn_released), 32'd0);
        end
        step(1);
        chk("midrst_no_early_press", 32'(cnt_p[0][5] - snap_p), 32'd0);
        rst_n = 1'b1;
        wait_state(0, 5, cyc, 60, edges, ok);
        chk("midrst_press5_seen", 32'(ok), 32'd1);
        chk_range("midrst_press5_latency", edges, 33, 43);
        chk("midrst_press5_pulse", 32'(bus_a.btn_pressed[5]), 32'd1);

        // ---- Active-high instance: press bit 7, then a 1-cycle glitch ----
        step(1);
        bus_b.btn_raw[7] = 1'b1;
        wait_state(1, 7, cyc, 60, edges, ok);
        chk("inv0_press7_seen", 32'(ok), 32'd1);
        chk_range("inv0_press7_latency", edges, 33, 43);
        chk("inv0_press7_pulse", 32'(bus_b.btn_pressed), 32'h80);
        step(5);
        snap_p = cnt_p[1][7];
        snap_r = cnt_r[1][7];
        bus_b.btn_raw[7] = 1'b0; step(1);
        bus_b.btn_raw[7] = 1'b1; step(50);
        chk("inv0_glitch_state", 32'(bus_b.btn_state[7]), 32'd1);
        chk("inv0_glitch_no_release", 32'(cnt_r[1][7] - snap_r), 32'd0);
        chk("inv0_glitch_no_press", 32'(cnt_p[1][7] - snap_p), 32'd0);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart of the LED blinker. The blinker drives 8 LED outputs; this block reads 8 raw board buttons/switches.
- Per input it synchronizes, debounces on a shared millisecond tick, and publishes a stable level plus one-cycle press/release pulses.
- It sits between the board pins and the control logic that picks blink modes.

Parameters:
- CLK_FREQ, 25_000_000: system clock frequency in Hz; must be ≥ 1000.
- N, 8: number of button inputs.
- DEBOUNCE_MS, 20: number of consecutive ms ticks an input must differ from its current state before the change is accepted; must be ≥ 1.
- INVERT, 1: 1 = pins are active-low (pressed reads 0); 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_raw  input  N  raw asynchronous button pins.
- btn_state  output  N  debounced level; 1 = pressed.
- btn_pressed  output  N  one-cycle pulse on an accepted 0→1 of btn_state.
- btn_released  output  N  one-cycle pulse on an accepted 1→0 of btn_state.
- tick_ms  output  1  one-cycle pulse once per ms; exported for other blocks.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - btn_state, btn_pressed, btn_released, tick_ms, tick divider and all per-bit counters go to 0.
  - Both synchronizer stages go to {N{INVERT}}, i.e. the "released" pin level.
- Tick generator:
  - TICK_DIV = CLK_FREQ/1000 (integer division).
  - Divider counts 0..TICK_DIV-1 and wraps to 0.
  - tick_ms=1 exactly in the cycle where divider == TICK_DIV-1.
  - If TICK_DIV == 1, tick_ms is 1 every cycle after reset.
- Synchronizer:
  - 2-FF per bit.
  - s = sync2 XOR {N{INVERT}}, so s=1 means pressed.
- Per-bit debounce, bits fully independent:
  - Counter width is $clog2(DEBOUNCE_MS+1); the counter saturates and never wraps.
  - If s == btn_state: counter <= 0. Any bounce back restarts the count.
  - Else, on tick_ms: if counter == DEBOUNCE_MS-1, then btn_state <= s, counter <= 0, and the matching pulse (btn_pressed if s=1, else btn_released) is high the next cycle only. Otherwise counter <= counter+1.
  - Else, without tick_ms: counter holds.
- Pulse rules:
  - btn_pressed and btn_released are registered; each is high for exactly 1 cycle, coincident with the first cycle of the new btn_state.
  - They are never both high for the same bit.
  - Several bits may pulse in the same cycle.
- Latency: from a clean pin edge to the btn_state change is 2 sync cycles plus between (DEBOUNCE_MS-1)*TICK_DIV+1 and DEBOUNCE_MS*TICK_DIV cycles, depending on tick phase.
- Glitch rejection: a pulse shorter than (DEBOUNCE_MS-1)*TICK_DIV cycles never changes btn_state.
- Reset mid-debounce: the count is lost and no pulse is emitted. After release from reset, a still-pressed button must re-qualify for a full DEBOUNCE_MS window.
- No combinational path from btn_raw to any output.

Decomposition:
- Shared package (blink_pkg):
  - MS_PER_S = 1000
  - function for TICK_DIV from CLK_FREQ
  - clog2 helper for counter widths
- Sub-module debounce_cell, one instance per bit, generate loop.
  - Inputs: clk, rst_n, s, tick.
  - Outputs: state, rise, fall.
  - Parameter: DEBOUNCE_MS.
- The tick divider and synchronizers stay in the top module.

Test Plan:
- Test config for all scenarios: CLK_FREQ=10_000 (TICK_DIV=10), DEBOUNCE_MS=4, INVERT=1.
- Reset: hold rst_n=0 with btn_raw=8'hFF, release → all outputs 0; tick_ms first pulses 10 cycles after release, then every 10 cycles.
- Clean press: drive btn_raw[0]=0 and hold → btn_state[0] rises within 33–43 cycles; btn_pressed[0] high for exactly that one cycle; other bits unchanged.
- Bounce: toggle btn_raw[3] low 25 cycles, high 5, low 25, high → btn_state[3] stays 0 and no pulses. Then hold low 50 cycles → a single btn_pressed[3] pulse.
- Release and multi-bit: with bits 1 and 2 pressed, release both in the same cycle → btn_released[1] and btn_released[2] pulse in the same cycle; btn_pressed stays 0.
- Reset mid-count: press bit 5, assert rst_n at cycle 25 for 3 cycles while still pressed → no pulse during reset; after release, btn_state[5] rises only after a fresh 33–43 cycle window.
- INVERT=0 variant: btn_raw[7]=1 held → btn_state[7]=1 with a btn_pressed[7] pulse. Then force a 1-cycle low glitch → no change.
